// File: rtl/interrupt_ack_sequencer_if.sv
// rtl/interrupt_ack_sequencer_if.sv - request, INTA, OCW2 and vector signals of the acknowledge sequencer
interface interrupt_ack_sequencer_if;
  logic [7:0] interrupt_request;
  logic [7:0] in_service_register;
  logic       inta_n;
  logic [4:0] vector_base;
  logic       auto_eoi;
  logic       ocw2_write;
  logic [7:0] ocw2_data;
  logic       int_out;
  logic       latch_in_service;
  logic [7:0] interrupt;
  logic [7:0] end_of_interrupt;
  logic [2:0] priority_rotate;
  logic [7:0] vector_out;
  logic       vector_drive;

  modport slave (
    input  interrupt_request, in_service_register, inta_n, vector_base,
           auto_eoi, ocw2_write, ocw2_data,
    output int_out, latch_in_service, interrupt, end_of_interrupt,
           priority_rotate, vector_out, vector_drive
  );

  modport master (
    output interrupt_request, in_service_register, inta_n, vector_base,
           auto_eoi, ocw2_write, ocw2_data,
    input  int_out, latch_in_service, interrupt, end_of_interrupt,
           priority_rotate, vector_out, vector_drive
  );
endinterface

// File: rtl/interrupt_ack_sequencer.sv
// rtl/interrupt_ack_sequencer.sv - priority resolve, two-pulse INTA sequencing, EOI and rotation control
module interrupt_ack_sequencer (
  input  logic                        clk,
  input  logic                        reset,
  interrupt_ack_sequencer_if.slave    bus
);
  typedef enum logic [1:0] {IDLE, ACK1, WAIT2, ACK2} state_t;

  state_t     state_q, state_d;
  logic       inta_prev_q;
  logic [2:0] ack_level_q, ack_level_d;
  logic       spurious_q, spurious_d;
  logic       int_out_q, int_out_d;
  logic       latch_q, latch_d;
  logic [7:0] interrupt_q, interrupt_d;
  logic [7:0] eoi_q, eoi_d;
  logic [2:0] rotate_q, rotate_d;
  logic       rotate_in_aeoi_q, rotate_in_aeoi_d;
  logic [7:0] vector_q, vector_d;
  logic       drive_q, drive_d;

  logic [3:0] req_res, isr_res;
  logic       inta_fall, req_wins, aeoi_fire;
  logic [2:0] ocw2_level;
  logic       unused_ocw2_bits;

  // Returns {found, level}; scanning from lowest to highest priority so the last hit wins.
  function automatic logic [3:0] resolve(input logic [7:0] bits, input logic [2:0] rot);
    logic [3:0] res;
    logic [2:0] lvl;
    res = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      lvl = rot + 3'(i) + 3'd1;
      if (bits[lvl]) res = {1'b1, lvl};
    end
    return res;
  endfunction

  function automatic logic [2:0] rank(input logic [2:0] lvl, input logic [2:0] rot);
    return lvl - rot - 3'd1;
  endfunction

  function automatic logic [7:0] onehot(input logic [2:0] lvl);
    return 8'd1 << lvl;
  endfunction

  assign req_res          = resolve(bus.interrupt_request, rotate_q);
  assign isr_res          = resolve(bus.in_service_register, rotate_q);
  assign inta_fall        = !bus.inta_n && inta_prev_q;
  assign req_wins         = req_res[3] &&
                            (!isr_res[3] || (rank(req_res[2:0], rotate_q) < rank(isr_res[2:0], rotate_q)));
  assign aeoi_fire        = (state_q == ACK2) && bus.inta_n && bus.auto_eoi && !spurious_q;
  assign ocw2_level       = bus.ocw2_data[2:0];
  assign unused_ocw2_bits = ^bus.ocw2_data[4:3];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      inta_prev_q      <= 1'b1;
      ack_level_q      <= 3'd0;
      spurious_q       <= 1'b0;
      int_out_q        <= 1'b0;
      latch_q          <= 1'b0;
      interrupt_q      <= 8'd0;
      eoi_q            <= 8'd0;
      rotate_q         <= 3'd7;
      rotate_in_aeoi_q <= 1'b0;
      vector_q         <= 8'd0;
      drive_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      inta_prev_q      <= bus.inta_n;
      ack_level_q      <= ack_level_d;
      spurious_q       <= spurious_d;
      int_out_q        <= int_out_d;
      latch_q          <= latch_d;
      interrupt_q      <= interrupt_d;
      eoi_q            <= eoi_d;
      rotate_q         <= rotate_d;
      rotate_in_aeoi_q <= rotate_in_aeoi_d;
      vector_q         <= vector_d;
      drive_q          <= drive_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ack_level_d = ack_level_q;
    spurious_d  = spurious_q;
    case (state_q)
      IDLE: if (inta_fall) begin
        state_d     = ACK1;
        ack_level_d = req_res[3] ? req_res[2:0] : 3'd7;
        spurious_d  = !req_res[3];
      end
      ACK1:    if (bus.inta_n) state_d = WAIT2;
      WAIT2:   if (inta_fall)  state_d = ACK2;
      ACK2:    if (bus.inta_n) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    int_out_d        = (state_q == IDLE) && !inta_fall && req_wins;
    latch_d          = (state_q == IDLE) && inta_fall && req_res[3];
    interrupt_d      = latch_d ? onehot(req_res[2:0]) : 8'd0;
    drive_d          = (state_d == ACK2);
    vector_d         = drive_d ? {bus.vector_base, ack_level_d} : 8'd0;
    eoi_d            = 8'd0;
    rotate_d         = rotate_q;
    rotate_in_aeoi_d = rotate_in_aeoi_q;
    if (aeoi_fire) begin
      eoi_d = onehot(ack_level_q);
      if (rotate_in_aeoi_q) rotate_d = ack_level_q;
    end
    // OCW2 is applied after AEOI so its rotation takes precedence in a shared cycle.
    if (bus.ocw2_write) begin
      case (bus.ocw2_data[7:5])
        3'b001: if (isr_res[3]) eoi_d = eoi_d | onehot(isr_res[2:0]);
        3'b011: eoi_d = eoi_d | onehot(ocw2_level);
        3'b101: if (isr_res[3]) begin
          eoi_d    = eoi_d | onehot(isr_res[2:0]);
          rotate_d = isr_res[2:0];
        end
        3'b111: begin
          eoi_d    = eoi_d | onehot(ocw2_level);
          rotate_d = ocw2_level;
        end
        3'b110:  rotate_d = ocw2_level;
        3'b100:  rotate_in_aeoi_d = 1'b1;
        3'b000:  rotate_in_aeoi_d = 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.int_out          = int_out_q;
  assign bus.latch_in_service = latch_q;
  assign bus.interrupt        = interrupt_q;
  assign bus.end_of_interrupt = eoi_q;
  assign bus.priority_rotate  = rotate_q;
  assign bus.vector_out       = vector_q;
  assign bus.vector_drive     = drive_q;
endmodule
